load_unit_mc: RTL and testbench
===============================

# load_unit_mc

Multi-channel, sequential successor to the two-port load classifier. It accepts a batch of N_CH load addresses in one valid/ready handshake and classifies each enabled channel as local (coordinates match X_COORD/Y_COORD) or remote. Local loads go to the tile's single-port memory at one per cycle. Remote loads go to the fetch unit under a valid/ready handshake. The block sits between the aggregation request source and the local memory / fetch unit pair.

## Interface
Parameters:
- X_COORD, default 1: this tile's x coordinate.
- Y_COORD, default 1: this tile's y coordinate.
- N_CH, default 4: address channels per request, ≥1.
- Derived: CH_W = max(1, $clog2(N_CH)); MW = $clog2(MEM_HEIGHT).
- ADDR_LENGTH, COORD_LENGTH and MEM_HEIGHT come from my_pkg.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_vld  in  1  batch request valid.
- req_rdy  out  1  block can accept a batch.
- req_addr  in  N_CH×ADDR_LENGTH  packed addresses; channel i occupies slice i.
- req_ch_en  in  N_CH  per-channel enable.
- mem_vld  out  1  local memory read strobe.
- mem_addr  out  MW  memory row.
- mem_ch_mask  out  N_CH  channels served by this read.
- fetch_vld  out  1  remote fetch request valid.
- fetch_rdy  in  1  fetch unit accepts.
- fetch_x, fetch_y  out  COORD_LENGTH each  target tile coordinates.
- fetch_addr  out  MW  remote row.
- fetch_ch  out  CH_W  originating channel.
- done  out  1  one-cycle pulse when a batch is fully issued.

## Operation
- Address fields:
  - x = addr[ADDR_LENGTH-1 -: COORD_LENGTH].
  - y = addr[ADDR_LENGTH-COORD_LENGTH-1 -: COORD_LENGTH].
  - row = addr[MW-1:0].
- A channel is local iff its x == X_COORD and its y == Y_COORD.
- FSM states are IDLE and BUSY.
- IDLE:
  - req_rdy = 1.
  - On req_vld, the addresses are registered.
  - loc_pend is set to en & local; rem_pend is set to en & ~local.
  - If both masks are zero, the FSM stays in IDLE. Otherwise it goes to BUSY.
- BUSY:
  - req_rdy = 0.
  - Each cycle, if loc_pend ≠ 0, the lowest-index pending local channel i is issued:
    - mem_vld = 1, mem_addr = row_i, mem_ch_mask = one-hot(i).
    - Bit i of loc_pend is cleared at the clock edge.
    - Memory never back-pressures.
  - In parallel, if rem_pend ≠ 0, fetch_vld = 1 with the lowest-index pending remote channel's x, y, row and index.
    - The bit clears only on fetch_vld && fetch_rdy.
    - The payload is held stable while stalled.
  - Local and remote issue proceed concurrently and independently.
  - When both masks become zero at an edge, the next state is IDLE and done = 1 for exactly that first IDLE cycle.
- mem_*, fetch_* and done are driven from registered state only. There is no combinational path from req_* to any output. fetch_vld does not depend on fetch_rdy.
- Reset values:
  - state = IDLE, req_rdy = 1, both masks = 0.
  - mem_vld = 0, fetch_vld = 0, done = 0.
  - mem_addr, mem_ch_mask, fetch_x, fetch_y, fetch_addr, fetch_ch = 0.
- Reset asserted mid-batch drops all pending channels immediately and does not pulse done.
- An all-disabled request (req_ch_en = 0) is accepted. It produces no issues, and done pulses the cycle after acceptance.

## Timing
- Request acceptance is at the edge where req_vld && req_rdy.
- First mem_vld or fetch_vld is asserted in the cycle after acceptance.
- Local issue rate is 1 read per cycle. A batch of L local and R remote channels with fetch_rdy held high completes issue in max(L, R) cycles. done follows one cycle later, together with req_rdy.
- A new batch can be accepted in the done cycle, so back-to-back throughput is max(L, R)+1 cycles per batch.
- Ordering: within each class, issue is by strictly ascending channel index.

## Configuration
- Macro: LOAD_UNIT_MC_DEDUP_EN.
- Defined:
  - When local channel i issues, every pending local channel j with row_j == row_i is served by the same read.
  - Their bits are set in mem_ch_mask and cleared from loc_pend together.
  - L therefore counts distinct local rows.
- Undefined:
  - mem_ch_mask is always one-hot.
  - Every local channel is read separately.
- Remote requests are never merged in either mode.

## Test plan
Directed scenarios use N_CH=4 and X_COORD=Y_COORD=1; addresses are written as (x, y, row).
- All local, fetch_rdy=1:
  - Stimulus: (1,1,3), (1,1,5), (1,1,7), (1,1,9), en=1111.
  - Response: mem_addr 3,5,7,9 on cycles 1–4 with masks 0001, 0010, 0100, 1000; done on cycle 5; fetch_vld stays 0.
- Mixed with fetch stall:
  - Stimulus: ch0 local row 2, ch1 (0,1,4), ch2 (2,2,6), ch3 local row 8; fetch_rdy=0 for 3 cycles, then 1.
  - Response: reads of rows 2 and 8 complete by cycle 2. fetch_ch=1 is held stable through the stall, then fetch_ch=2. done follows the last handshake by 1 cycle.
- Disabled channels:
  - Stimulus: en=0000.
  - Response: no mem_vld or fetch_vld; done on cycle 1; req_rdy stays 1.
- Reset mid-batch:
  - Stimulus: rst_n=0 while rem_pend=0110.
  - Response: fetch_vld=0 immediately; req_rdy=1 after release; no done pulse.
- Dedup (macro defined):
  - Stimulus: all four channels local at row 5.
  - Response: one read with mem_ch_mask=1111, done on cycle 2.
  - With the macro undefined: four reads of row 5, done on cycle 5.
- Back-to-back:
  - Stimulus: a second batch with req_vld held high.
  - Response: accepted in the done cycle, and its first issue appears the next cycle.

Source files
------------

// File: rtl/my_pkg.sv
// rtl/my_pkg.sv - shared address geometry for the tile memory system
//
// ADDR_LENGTH  : full load address width
// COORD_LENGTH : width of each tile coordinate field (x, y)
// MEM_HEIGHT   : rows in the tile's local memory
package my_pkg;
  parameter int ADDR_LENGTH  = 16;
  parameter int COORD_LENGTH = 4;
  parameter int MEM_HEIGHT   = 256;
endpackage

// File: rtl/load_unit_mc.sv
// rtl/load_unit_mc.sv - multi-channel local/remote load classifier and issuer
//
// Accepts a batch of N_CH addresses in one req_vld/req_rdy handshake.
// Each enabled channel is classified as local (x/y match this tile) or remote.
// Local loads issue to the single-port memory at one read per cycle.
// Remote loads issue to the fetch unit under fetch_vld/fetch_rdy.
// Both classes issue in ascending channel order and proceed concurrently.
//
// Optional feature macro: LOAD_UNIT_MC_DEDUP_EN
//   When defined, pending local channels sharing a row are served by one read.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   req_vld/req_rdy  batch handshake
//   req_addr         N_CH packed addresses, channel i in slice i
//   req_ch_en        per-channel enable
//   mem_vld          local read strobe
//   mem_addr         local row
//   mem_ch_mask      channels served by this read
//   fetch_vld/rdy    remote fetch handshake
//   fetch_x/y        target tile coordinates
//   fetch_addr       remote row
//   fetch_ch         originating channel
//   done             one-cycle pulse when a batch has fully issued
module load_unit_mc
  import my_pkg::*;
#(
  parameter int X_COORD = 1,
  parameter int Y_COORD = 1,
  parameter int N_CH    = 4,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int MW     = $clog2(MEM_HEIGHT)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_vld,
  output logic                     req_rdy,
  input  logic [N_CH*ADDR_LENGTH-1:0] req_addr,
  input  logic [N_CH-1:0]          req_ch_en,
  output logic                     mem_vld,
  output logic [MW-1:0]            mem_addr,
  output logic [N_CH-1:0]          mem_ch_mask,
  output logic                     fetch_vld,
  input  logic                     fetch_rdy,
  output logic [COORD_LENGTH-1:0]  fetch_x,
  output logic [COORD_LENGTH-1:0]  fetch_y,
  output logic [MW-1:0]            fetch_addr,
  output logic [CH_W-1:0]          fetch_ch,
  output logic                     done
);

  localparam logic [COORD_LENGTH-1:0] X_C = COORD_LENGTH'(X_COORD);
  localparam logic [COORD_LENGTH-1:0] Y_C = COORD_LENGTH'(Y_COORD);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                            state, state_nx;
  logic [N_CH-1:0][ADDR_LENGTH-1:0]  addr_q;
  logic [N_CH-1:0]                   loc_pend, rem_pend, loc_nx, rem_nx;
  logic [N_CH-1:0]                   req_local, mem_mask_c, rem_onehot;
  logic [CH_W-1:0]                   loc_idx, rem_idx;
  logic                              loc_any, rem_any;
  logic                              done_q, done_nx;
  logic [ADDR_LENGTH-1:0]            a_in, loc_a, rem_a;

  always_comb begin
    req_local = '0;
    a_in      = '0;
    for (int i = 0; i < N_CH; i++) begin
      a_in = req_addr[i*ADDR_LENGTH +: ADDR_LENGTH];
      req_local[i] = (a_in[ADDR_LENGTH-1 -: COORD_LENGTH] == X_C) &&
                     (a_in[ADDR_LENGTH-COORD_LENGTH-1 -: COORD_LENGTH] == Y_C);
    end
  end

  // Lowest pending index per class: scan downward so the lowest hit wins.
  always_comb begin
    loc_idx = '0;
    rem_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (loc_pend[i]) loc_idx = CH_W'(i);
      if (rem_pend[i]) rem_idx = CH_W'(i);
    end
    loc_any    = |loc_pend;
    rem_any    = |rem_pend;
    loc_a      = addr_q[loc_idx];
    rem_a      = addr_q[rem_idx];
    rem_onehot = N_CH'(1) << rem_idx;
    mem_mask_c = '0;
    for (int i = 0; i < N_CH; i++) begin
`ifdef LOAD_UNIT_MC_DEDUP_EN
      mem_mask_c[i] = loc_pend[i] && (addr_q[i][MW-1:0] == loc_a[MW-1:0]);
`else
      mem_mask_c[i] = loc_pend[i] && (CH_W'(i) == loc_idx);
`endif
    end
  end

  // Outputs come only from registered state; masks are zero outside BUSY.
  always_comb begin
    req_rdy     = (state == IDLE);
    mem_vld     = loc_any;
    mem_addr    = loc_any ? loc_a[MW-1:0] : '0;
    mem_ch_mask = mem_mask_c;
    fetch_vld   = rem_any;
    fetch_x     = rem_any ? rem_a[ADDR_LENGTH-1 -: COORD_LENGTH] : '0;
    fetch_y     = rem_any ? rem_a[ADDR_LENGTH-COORD_LENGTH-1 -: COORD_LENGTH] : '0;
    fetch_addr  = rem_any ? rem_a[MW-1:0] : '0;
    fetch_ch    = rem_any ? rem_idx : '0;
    done        = done_q;
  end

  always_comb begin
    state_nx = state;
    loc_nx   = loc_pend;
    rem_nx   = rem_pend;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (req_vld) begin
          loc_nx = req_ch_en & req_local;
          rem_nx = req_ch_en & ~req_local;
          // An empty batch completes immediately without entering BUSY.
          if (loc_nx == '0 && rem_nx == '0) done_nx = 1'b1;
          else                              state_nx = BUSY;
        end
      end
      BUSY: begin
        loc_nx = loc_pend & ~mem_mask_c;
        if (fetch_vld && fetch_rdy) rem_nx = rem_pend & ~rem_onehot;
        if (loc_nx == '0 && rem_nx == '0) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      loc_pend <= '0;
      rem_pend <= '0;
      done_q   <= 1'b0;
      addr_q   <= '0;
    end else begin
      state    <= state_nx;
      loc_pend <= loc_nx;
      rem_pend <= rem_nx;
      done_q   <= done_nx;
      if (state == IDLE && req_vld) addr_q <= req_addr;
    end
  end

endmodule

// File: tb/tb_load_unit_mc.sv
// tb/tb_load_unit_mc.sv - directed self-checking bench for load_unit_mc
module tb_load_unit_mc;
  import my_pkg::*;

  localparam int N_CH = 4;
  localparam int MW   = $clog2(MEM_HEIGHT);

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic                       req_vld;
  logic                       req_rdy;
  logic [N_CH*ADDR_LENGTH-1:0] req_addr;
  logic [N_CH-1:0]            req_ch_en;
  logic                       mem_vld;
  logic [MW-1:0]              mem_addr;
  logic [N_CH-1:0]            mem_ch_mask;
  logic                       fetch_vld;
  logic                       fetch_rdy;
  logic [COORD_LENGTH-1:0]    fetch_x, fetch_y;
  logic [MW-1:0]              fetch_addr;
  logic [1:0]                 fetch_ch;
  logic                       done;

  int tests = 0;
  int fails = 0;

  load_unit_mc #(.X_COORD(1), .Y_COORD(1), .N_CH(N_CH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_addr(req_addr), .req_ch_en(req_ch_en),
    .mem_vld(mem_vld), .mem_addr(mem_addr), .mem_ch_mask(mem_ch_mask),
    .fetch_vld(fetch_vld), .fetch_rdy(fetch_rdy), .fetch_x(fetch_x), .fetch_y(fetch_y),
    .fetch_addr(fetch_addr), .fetch_ch(fetch_ch), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [ADDR_LENGTH-1:0] mk(input int x, input int y, input int row);
    mk = {COORD_LENGTH'(x), COORD_LENGTH'(y), MW'(row)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a batch and complete its handshake; returns at cycle 1 after acceptance.
  task automatic accept(input logic [N_CH*ADDR_LENGTH-1:0] a, input logic [N_CH-1:0] en);
    req_addr  = a;
    req_ch_en = en;
    req_vld   = 1'b1;
    step();
    req_vld   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_vld = 1'b0; req_addr = '0; req_ch_en = '0; fetch_rdy = 1'b1;
    step(); step();
    tests++; if (req_rdy !== 1'b1) begin fails++; $display("FAIL reset req_rdy got %b want 1", req_rdy); end
    tests++; if ({mem_vld, fetch_vld, done} !== 3'b000) begin fails++; $display("FAIL reset strobes got %b want 000", {mem_vld, fetch_vld, done}); end
    tests++; if ({mem_addr, mem_ch_mask, fetch_x, fetch_y, fetch_addr, fetch_ch} !== '0) begin
      fails++; $display("FAIL reset payload got %h want 0", {mem_addr, mem_ch_mask, fetch_x, fetch_y, fetch_addr, fetch_ch}); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_all_local();
    logic [MW-1:0]   rows  [4] = '{8'd3, 8'd5, 8'd7, 8'd9};
    logic [N_CH-1:0] masks [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    fetch_rdy = 1'b1;
    accept({mk(1,1,9), mk(1,1,7), mk(1,1,5), mk(1,1,3)}, 4'b1111);
    for (int k = 0; k < 4; k++) begin
      tests++; if ({mem_vld, mem_addr, mem_ch_mask} !== {1'b1, rows[k], masks[k]}) begin
        fails++; $display("FAIL all_local c%0d mem got v%b a%0d m%b want v1 a%0d m%b", k+1, mem_vld, mem_addr, mem_ch_mask, rows[k], masks[k]); end
      tests++; if ({fetch_vld, done, req_rdy} !== 3'b000) begin
        fails++; $display("FAIL all_local c%0d fetch/done/rdy got %b want 000", k+1, {fetch_vld, done, req_rdy}); end
      step();
    end
    tests++; if ({done, req_rdy, mem_vld} !== 3'b110) begin
      fails++; $display("FAIL all_local c5 done/rdy/mem got %b want 110", {done, req_rdy, mem_vld}); end
    step();
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL all_local done_width got %b want 0", done); end
  endtask

  task automatic test_mixed_stall();
    fetch_rdy = 1'b0;
    accept({mk(1,1,8), mk(2,2,6), mk(0,1,4), mk(1,1,2)}, 4'b1111);
    tests++; if ({mem_vld, mem_addr, mem_ch_mask} !== {1'b1, 8'd2, 4'b0001}) begin
      fails++; $display("FAIL mixed c1 mem got v%b a%0d m%b want v1 a2 m0001", mem_vld, mem_addr, mem_ch_mask); end
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) fetch_rdy = 1'b1;
      tests++; if ({fetch_vld, fetch_ch, fetch_x, fetch_y, fetch_addr} !== {1'b1, 2'd1, 4'd0, 4'd1, 8'd4}) begin
        fails++; $display("FAIL mixed c%0d fetch got v%b ch%0d x%0d y%0d a%0d want v1 ch1 x0 y1 a4", k, fetch_vld, fetch_ch, fetch_x, fetch_y, fetch_addr); end
      if (k == 2) begin
        tests++; if ({mem_vld, mem_addr, mem_ch_mask} !== {1'b1, 8'd8, 4'b1000}) begin
          fails++; $display("FAIL mixed c2 mem got v%b a%0d m%b want v1 a8 m1000", mem_vld, mem_addr, mem_ch_mask); end
      end
      if (k == 3) begin
        tests++; if (mem_vld !== 1'b0) begin fails++; $display("FAIL mixed c3 mem_vld got %b want 0", mem_vld); end
      end
      step();
    end
    tests++; if ({fetch_vld, fetch_ch, fetch_x, fetch_y, fetch_addr, done} !== {1'b1, 2'd2, 4'd2, 4'd2, 8'd6, 1'b0}) begin
      fails++; $display("FAIL mixed c5 fetch got v%b ch%0d x%0d y%0d a%0d d%b want v1 ch2 x2 y2 a6 d0", fetch_vld, fetch_ch, fetch_x, fetch_y, fetch_addr, done); end
    step();
    tests++; if ({done, req_rdy, fetch_vld} !== 3'b110) begin
      fails++; $display("FAIL mixed c6 done/rdy/fetch got %b want 110", {done, req_rdy, fetch_vld}); end
    step();
  endtask

  task automatic test_disabled();
    fetch_rdy = 1'b1;
    accept({mk(1,1,1), mk(0,0,2), mk(1,1,3), mk(3,3,4)}, 4'b0000);
    tests++; if ({done, req_rdy, mem_vld, fetch_vld} !== 4'b1100) begin
      fails++; $display("FAIL disabled c1 done/rdy/mem/fetch got %b want 1100", {done, req_rdy, mem_vld, fetch_vld}); end
    step();
    tests++; if ({done, req_rdy, mem_vld, fetch_vld} !== 4'b0100) begin
      fails++; $display("FAIL disabled c2 done/rdy/mem/fetch got %b want 0100", {done, req_rdy, mem_vld, fetch_vld}); end
  endtask

  task automatic test_reset_mid();
    fetch_rdy = 1'b0;
    accept({mk(1,1,1), mk(2,0,6), mk(0,2,5), mk(1,1,2)}, 4'b0110);
    tests++; if ({fetch_vld, fetch_ch} !== {1'b1, 2'd1}) begin
      fails++; $display("FAIL rst_mid pre fetch got v%b ch%0d want v1 ch1", fetch_vld, fetch_ch); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if ({fetch_vld, req_rdy, done} !== 3'b010) begin
      fails++; $display("FAIL rst_mid async fetch/rdy/done got %b want 010", {fetch_vld, req_rdy, done}); end
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      tests++; if ({fetch_vld, req_rdy, done, mem_vld} !== 4'b0100) begin
        fails++; $display("FAIL rst_mid post c%0d fetch/rdy/done/mem got %b want 0100", k, {fetch_vld, req_rdy, done, mem_vld}); end
    end
  endtask

  task automatic test_dedup();
    fetch_rdy = 1'b1;
    accept({mk(1,1,5), mk(1,1,5), mk(1,1,5), mk(1,1,5)}, 4'b1111);
`ifdef LOAD_UNIT_MC_DEDUP_EN
    tests++; if ({mem_vld, mem_addr, mem_ch_mask} !== {1'b1, 8'd5, 4'b1111}) begin
      fails++; $display("FAIL dedup c1 mem got v%b a%0d m%b want v1 a5 m1111", mem_vld, mem_addr, mem_ch_mask); end
    step();
    tests++; if ({done, mem_vld} !== 2'b10) begin fails++; $display("FAIL dedup c2 done/mem got %b want 10", {done, mem_vld}); end
`else
    for (int k = 0; k < 4; k++) begin
      tests++; if ({mem_vld, mem_addr, mem_ch_mask} !== {1'b1, 8'd5, 4'(1 << k)}) begin
        fails++; $display("FAIL dedup c%0d mem got v%b a%0d m%b want v1 a5 m%b", k+1, mem_vld, mem_addr, mem_ch_mask, 4'(1 << k)); end
      step();
    end
    tests++; if ({done, mem_vld} !== 2'b10) begin fails++; $display("FAIL dedup c5 done/mem got %b want 10", {done, mem_vld}); end
`endif
    step();
  endtask

  task automatic test_back_to_back();
    fetch_rdy = 1'b1;
    accept({mk(0,0,0), mk(0,0,0), mk(1,1,2), mk(1,1,1)}, 4'b0011);
    req_addr  = {mk(0,0,0), mk(3,0,7), mk(0,0,0), mk(0,0,0)};
    req_ch_en = 4'b0100;
    req_vld   = 1'b1;
    tests++; if ({mem_vld, mem_addr, req_rdy} !== {1'b1, 8'd1, 1'b0}) begin
      fails++; $display("FAIL b2b c1 got v%b a%0d rdy%b want v1 a1 rdy0", mem_vld, mem_addr, req_rdy); end
    step();
    tests++; if ({mem_vld, mem_addr} !== {1'b1, 8'd2}) begin
      fails++; $display("FAIL b2b c2 got v%b a%0d want v1 a2", mem_vld, mem_addr); end
    step();
    tests++; if ({done, req_rdy} !== 2'b11) begin fails++; $display("FAIL b2b c3 done/rdy got %b want 11", {done, req_rdy}); end
    step();
    req_vld = 1'b0;
    tests++; if ({fetch_vld, fetch_ch, fetch_x, fetch_y, fetch_addr, done, req_rdy} !== {1'b1, 2'd2, 4'd3, 4'd0, 8'd7, 1'b0, 1'b0}) begin
      fails++; $display("FAIL b2b c4 got v%b ch%0d x%0d y%0d a%0d d%b r%b want v1 ch2 x3 y0 a7 d0 r0", fetch_vld, fetch_ch, fetch_x, fetch_y, fetch_addr, done, req_rdy); end
    step();
    tests++; if ({done, req_rdy, fetch_vld} !== 3'b110) begin fails++; $display("FAIL b2b c5 done/rdy/fetch got %b want 110", {done, req_rdy, fetch_vld}); end
    step();
  endtask

  initial begin
    test_reset();
    test_all_local();
    test_mixed_stall();
    test_disabled();
    test_reset_mid();
    test_dedup();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
